// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the IF/ID and ID/EX pipeline registers: load-use stalls,
// branch-mispredict squash and an optional mult/div interlock (enable with MULDIV_INTERLOCK_EN).
module pipe_hazard_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 32,
    parameter int unsigned CNT_W         = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_muldiv,
    input  logic        id_hilo_read,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_write_reg,
    input  logic        ex_mispredict,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        muldiv_busy,
    output logic [15:0] stall_cycles
);

    logic        load_use;
    logic        hilo_stall;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    // r0 is hardwired to zero, so a load targeting it can never create a dependency.
    assign load_use = ex_mem_read & (ex_write_reg != 5'd0) &
                      ((id_uses_rs & (id_rs == ex_write_reg)) |
                       (id_uses_rt & (id_rt == ex_write_reg)));

`ifdef MULDIV_INTERLOCK_EN
    typedef enum logic [0:0] {StRun, StBusy} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             muldiv_issue;

    assign hilo_stall   = (state_q == StBusy) & (id_muldiv | id_hilo_read);
    assign muldiv_busy  = (state_q == StBusy);
    assign muldiv_issue = id_muldiv & (state_q == StRun) & ~load_use & ~ex_mispredict & ~rst;

    // A mispredict never leaves BUSY: the mult/div in flight is older than the branch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (rst) begin
            state_d = StRun;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (muldiv_issue) begin
                        state_d = StBusy;
                        cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
                    end
                end
                StBusy: begin
                    if (cnt_q == '0) begin
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end
`else
    logic             unused_muldiv_in;
    logic [CNT_W-1:0] unused_cnt_init;

    assign unused_muldiv_in = id_muldiv ^ id_hilo_read;
    assign unused_cnt_init  = CNT_W'(MULDIV_CYCLES - 1);
    assign hilo_stall       = 1'b0;
    assign muldiv_busy      = 1'b0;
`endif

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (ex_mispredict) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use | hilo_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (rst) begin
            stall_cycles_d = '0;
        end else if (!pc_write && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, hand-written multi-cycle sequences
// and randomized traffic against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MC = 4;
`ifdef MULDIV_INTERLOCK_EN
    localparam bit Interlock = 1'b1;
`else
    localparam bit Interlock = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_write_reg;
    logic        id_uses_rs, id_uses_rt, id_muldiv, id_hilo_read;
    logic        ex_mem_read, ex_mispredict;
    logic        pc_write, ifid_write, ifid_flush, idex_flush, muldiv_busy;
    logic [15:0] stall_cycles;

    pipe_hazard_ctrl #(
        .MULDIV_CYCLES(MC),
        .CNT_W        (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_muldiv    (id_muldiv),
        .id_hilo_read (id_hilo_read),
        .ex_mem_read  (ex_mem_read),
        .ex_write_reg (ex_write_reg),
        .ex_mispredict(ex_mispredict),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .muldiv_busy  (muldiv_busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: remaining busy cycles and a plain integer stall count.
    int busy_left = 0;
    int stall_cnt = 0;
    bit e_pc, e_ifw, e_iff, e_idf, e_busy, e_issue;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic model_eval();
        bit lu, hs, dep_rs, dep_rt;
        e_busy = Interlock && (busy_left > 0);
        dep_rs = id_uses_rs && (id_rs == ex_write_reg);
        dep_rt = id_uses_rt && (id_rt == ex_write_reg);
        lu     = ex_mem_read && (ex_write_reg != 0) && (dep_rs || dep_rt);
        hs     = e_busy && (id_muldiv || id_hilo_read);
        if (rst) {e_pc, e_ifw, e_iff, e_idf} = 4'b0011;
        else if (ex_mispredict) {e_pc, e_ifw, e_iff, e_idf} = 4'b1111;
        else if (lu || hs) {e_pc, e_ifw, e_iff, e_idf} = 4'b0001;
        else {e_pc, e_ifw, e_iff, e_idf} = 4'b1100;
        e_issue = Interlock && id_muldiv && !e_busy && !lu && !ex_mispredict && !rst;
    endtask

    task automatic model_clock();
        if (rst) begin
            busy_left = 0;
            stall_cnt = 0;
        end else begin
            if (busy_left > 0) busy_left--;
            else if (e_issue) busy_left = MC;
            if (!e_pc && stall_cnt < 65535) stall_cnt++;
        end
    endtask

    task automatic step(input string name);
        model_eval();
        #1;
        check(name, {pc_write, ifid_write, ifid_flush, idex_flush, muldiv_busy, stall_cycles},
              {e_pc, e_ifw, e_iff, e_idf, e_busy, 16'(stall_cnt)});
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; id_rs = '0; id_rt = '0; ex_write_reg = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_muldiv = 1'b0; id_hilo_read = 1'b0;
        ex_mem_read = 1'b0; ex_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step("reset");
        rst = 1'b0;
    endtask

    task automatic load_use_stim();
        ex_mem_read = 1'b1; ex_write_reg = 5'd8; id_uses_rs = 1'b1; id_rs = 5'd8;
    endtask

    typedef struct {
        logic       rst, mem_read, mis, uses_rs, uses_rt;
        logic [4:0] rs, rt, wr;
        logic [3:0] ctl;  // {pc_write, ifid_write, ifid_flush, idex_flush}
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  4'b1100};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8,  5'd0,  5'd8,  4'b0001};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  4'b1100};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1,  5'd5,  5'd5,  4'b0001};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5,  5'd5,  5'd5,  4'b1100};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9,  5'd9,  5'd9,  4'b1100};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8,  5'd0,  5'd8,  4'b1111};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  4'b1111};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd31, 5'd30, 5'd31, 4'b1100};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 5'd31, 5'd31, 4'b0001};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8,  5'd0,  5'd8,  4'b0011};

        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        step("reset_state");
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            idle();
            rst = tbl[i].rst; ex_mem_read = tbl[i].mem_read; ex_mispredict = tbl[i].mis;
            id_uses_rs = tbl[i].uses_rs; id_uses_rt = tbl[i].uses_rt;
            id_rs = tbl[i].rs; id_rt = tbl[i].rt; ex_write_reg = tbl[i].wr;
            #1;
            check($sformatf("tbl%0d_ctl", i), {pc_write, ifid_write, ifid_flush, idex_flush},
                  tbl[i].ctl);
            step($sformatf("tbl%0d", i));
        end

        // Load-use lasts one cycle, then the front end advances.
        do_reset();
        load_use_stim();
        step("lu_stall");
        idle();
        #1;
        check("lu_next_pc", pc_write, 1);
        check("lu_count", stall_cycles, 16'd1);
        step("lu_next");

        // Mispredict during a load-use squashes and does not count as a stall.
        load_use_stim();
        ex_mispredict = 1'b1;
        #1;
        check("mis_lu_ctl", {pc_write, ifid_flush, idex_flush}, 3'b111);
        step("mis_lu");
        idle();
        #1;
        check("mis_lu_count", stall_cycles, 16'd1);

        // Mult then mfhi: mfhi waits out the whole busy window.
        do_reset();
        id_muldiv = 1'b1;
        #1;
        check("mult_issue_pc", pc_write, 1);
        step("mult_issue");
        id_muldiv = 1'b0;
        id_hilo_read = 1'b1;
        for (int i = 0; i < MC; i++) begin
            #1;
            check($sformatf("busy_c%0d", i), {muldiv_busy, pc_write}, {Interlock, !Interlock});
            step($sformatf("mfhi_wait%0d", i));
        end
        #1;
        check("mfhi_go", {muldiv_busy, pc_write}, 2'b01);
        check("mfhi_count", stall_cycles, Interlock ? MC : 0);
        step("mfhi_go");

        // Reset in the middle of the busy window.
        do_reset();
        id_muldiv = 1'b1;
        step("mult_issue2");
        id_muldiv = 1'b0;
        id_hilo_read = 1'b1;
        step("busy_cnt3");
        rst = 1'b1;
        step("rst_mid_busy");
        rst = 1'b0;
        #1;
        check("after_rst", {muldiv_busy, pc_write, stall_cycles}, {2'b01, 16'd0});
        step("after_rst_mfhi");

        // Saturation of the stall counter.
        do_reset();
        load_use_stim();
        repeat (70000) @(posedge clk);
        #1;
        check("sat_value", stall_cycles, 16'hFFFF);
        check("sat_pc", pc_write, 0);
        repeat (3) @(posedge clk);
        #1;
        check("sat_hold", stall_cycles, 16'hFFFF);
        stall_cnt = 65535;
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            id_rs         = 5'($urandom_range(0, 3));
            id_rt         = 5'($urandom_range(0, 3));
            ex_write_reg  = 5'($urandom_range(0, 3));
            id_uses_rs    = 1'($urandom);
            id_uses_rt    = 1'($urandom);
            ex_mem_read   = 1'($urandom);
            ex_mispredict = ($urandom_range(0, 7) == 0);
            id_muldiv     = ($urandom_range(0, 3) == 0);
            id_hilo_read  = ($urandom_range(0, 3) == 0);
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
